// File: rtl/rgmii_tx_ddr_seq_if.sv
// MAC-side and ODDR-side signals of the RGMII transmit DDR sequencer.
// RGMII_TX_SPEED_STATUS_EN adds speed_active / speed_chg status outputs.
interface rgmii_tx_ddr_seq_if;
    logic [1:0] speed;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       mac_clk_en;
    logic [3:0] txd_d1;
    logic [3:0] txd_d2;
    logic       txctl_d1;
    logic       txctl_d2;
    logic       txc_d1;
    logic       txc_d2;
`ifdef RGMII_TX_SPEED_STATUS_EN
    logic [1:0] speed_active;
    logic [0:0] speed_chg;
`endif

    modport master (
        output speed, gmii_txd, gmii_tx_en, gmii_tx_er,
`ifdef RGMII_TX_SPEED_STATUS_EN
        input  speed_active, speed_chg,
`endif
        input  mac_clk_en, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2
    );

    modport slave (
        input  speed, gmii_txd, gmii_tx_en, gmii_tx_er,
`ifdef RGMII_TX_SPEED_STATUS_EN
        output speed_active, speed_chg,
`endif
        output mac_clk_en, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2
    );
endinterface

// File: rtl/rgmii_tx_ddr_seq.sv
// RGMII TX DDR sequencer: GMII bytes to per-cycle d1/d2 ODDR data, TXC and MAC byte strobe.
// Optional RGMII_TX_SPEED_STATUS_EN exposes the latched speed and a change pulse.
module rgmii_tx_ddr_seq #(
    parameter int unsigned CNT_100 = 5,
    parameter int unsigned CNT_10  = 50
) (
    input  logic              clk,
    input  logic              rst,
    rgmii_tx_ddr_seq_if.slave bus
);
    localparam int unsigned CNT_MAX = (CNT_10 > CNT_100) ? CNT_10 : CNT_100;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    typedef enum logic {NIB_LOW, NIB_HIGH} nib_t;

    function automatic logic [CW-1:0] period_m1(input logic [1:0] spd);
        return (spd == 2'b00) ? CW'(CNT_10 - 1) : CW'(CNT_100 - 1);
    endfunction

    // TXC high for the first P half-cycles of a 2P half-cycle period
    function automatic logic [1:0] txc_pat(input logic [1:0] spd, input logic [CW-1:0] c);
        int unsigned p;
        logic [CW-1:0] half;
        p    = (spd == 2'b00) ? CNT_10 : CNT_100;
        half = CW'(p / 2);
        if (c < half)                    return 2'b11;
        else if ((p % 2 == 1) && c == half) return 2'b10;
        else                             return 2'b00;
    endfunction

    logic [1:0]    spd_q, spd_n;
    logic [CW-1:0] cyc_q, cyc_n;
    nib_t          nib_q, nib_n;
    logic [7:0]    held_q, held_n;
    logic          hen_q, hen_n, her_q, her_n;
    logic          mce_q, mce_n;
    logic [3:0]    txd1_q, txd1_n, txd2_q, txd2_n;
    logic          ctl1_q, ctl1_n, ctl2_q, ctl2_n;
    logic [1:0]    txc_q, txc_n;
    logic [3:0]    nibble;

    // Next state and next registered outputs
    always_comb begin
        spd_n  = spd_q;
        cyc_n  = cyc_q;
        nib_n  = nib_q;
        held_n = held_q;
        hen_n  = hen_q;
        her_n  = her_q;
        mce_n  = 1'b0;
        txd1_n = '0;
        txd2_n = '0;
        ctl1_n = 1'b0;
        ctl2_n = 1'b0;
        txc_n  = 2'b00;
        nibble = '0;

        if (spd_q[1]) begin
            // every gigabit cycle is a byte boundary; leaving it restarts idle
            spd_n  = bus.speed;
            cyc_n  = '0;
            nib_n  = NIB_LOW;
            held_n = '0;
            hen_n  = 1'b0;
            her_n  = 1'b0;
        end else if (cyc_q == period_m1(spd_q)) begin
            cyc_n = '0;
            if (nib_q == NIB_HIGH) begin
                nib_n  = NIB_LOW;
                spd_n  = bus.speed;
                held_n = bus.gmii_txd;
                hen_n  = bus.gmii_tx_en;
                her_n  = bus.gmii_tx_er;
            end else begin
                nib_n = NIB_HIGH;
            end
        end else begin
            cyc_n = cyc_q + CW'(1);
        end

        if (spd_n[1]) begin
            mce_n = 1'b1;
            txc_n = 2'b10;
            if (mce_q) begin
                txd1_n = bus.gmii_txd[3:0];
                txd2_n = bus.gmii_txd[7:4];
                ctl1_n = bus.gmii_tx_en;
                ctl2_n = bus.gmii_tx_en ^ bus.gmii_tx_er;
            end
        end else begin
            mce_n  = (cyc_n == period_m1(spd_n)) && (nib_n == NIB_HIGH);
            txc_n  = txc_pat(spd_n, cyc_n);
            nibble = (nib_n == NIB_HIGH) ? held_n[7:4] : held_n[3:0];
            txd1_n = nibble;
            txd2_n = nibble;
            ctl1_n = hen_n;
            ctl2_n = hen_n ^ her_n;
        end
    end

`ifdef RGMII_TX_SPEED_STATUS_EN
    logic chg_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            spd_q  <= bus.speed;
            cyc_q  <= '0;
            nib_q  <= NIB_LOW;
            held_q <= '0;
            hen_q  <= 1'b0;
            her_q  <= 1'b0;
            mce_q  <= 1'b0;
            txd1_q <= '0;
            txd2_q <= '0;
            ctl1_q <= 1'b0;
            ctl2_q <= 1'b0;
            txc_q  <= 2'b00;
`ifdef RGMII_TX_SPEED_STATUS_EN
            chg_q  <= 1'b0;
`endif
        end else begin
            spd_q  <= spd_n;
            cyc_q  <= cyc_n;
            nib_q  <= nib_n;
            held_q <= held_n;
            hen_q  <= hen_n;
            her_q  <= her_n;
            mce_q  <= mce_n;
            txd1_q <= txd1_n;
            txd2_q <= txd2_n;
            ctl1_q <= ctl1_n;
            ctl2_q <= ctl2_n;
            txc_q  <= txc_n;
`ifdef RGMII_TX_SPEED_STATUS_EN
            chg_q  <= (spd_n != spd_q);
`endif
        end
    end

    assign bus.mac_clk_en = mce_q;
    assign bus.txd_d1     = txd1_q;
    assign bus.txd_d2     = txd2_q;
    assign bus.txctl_d1   = ctl1_q;
    assign bus.txctl_d2   = ctl2_q;
    assign bus.txc_d1     = txc_q[1];
    assign bus.txc_d2     = txc_q[0];
`ifdef RGMII_TX_SPEED_STATUS_EN
    assign bus.speed_active = spd_q;
    assign bus.speed_chg    = chg_q;
`endif
endmodule

// File: tb/tb_rgmii_tx_ddr_seq.sv
// Directed bench for rgmii_tx_ddr_seq: gigabit path, 100/10 nibble sequencing, speed switches, reset.
module tb_rgmii_tx_ddr_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgmii_tx_ddr_seq_if bus ();
    rgmii_tx_ddr_seq #(.CNT_100(5), .CNT_10(50)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] pat5 [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic mce, input logic [3:0] t1, input logic [3:0] t2,
                           input logic c1, input logic c2, input logic k1, input logic k2);
        chk({tag, ".mce"}, 32'(bus.mac_clk_en), 32'(mce));
        chk({tag, ".txd1"}, 32'(bus.txd_d1), 32'(t1));
        chk({tag, ".txd2"}, 32'(bus.txd_d2), 32'(t2));
        chk({tag, ".ctl1"}, 32'(bus.txctl_d1), 32'(c1));
        chk({tag, ".ctl2"}, 32'(bus.txctl_d2), 32'(c2));
        chk({tag, ".txc1"}, 32'(bus.txc_d1), 32'(k1));
        chk({tag, ".txc2"}, 32'(bus.txc_d2), 32'(k2));
    endtask

    task automatic chk_status(input string tag, input logic [1:0] sa, input logic sc);
`ifdef RGMII_TX_SPEED_STATUS_EN
        chk({tag, ".spd_act"}, 32'(bus.speed_active), 32'(sa));
        chk({tag, ".spd_chg"}, 32'(bus.speed_chg), 32'(sc));
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic en, input logic er);
        bus.gmii_txd   = d;
        bus.gmii_tx_en = en;
        bus.gmii_tx_er = er;
    endtask

    initial begin
        logic [1:0]  tp;
        logic [3:0]  en_nib;
        logic        c1, c2, mce;

        // gigabit: reset then back-to-back bytes
        rst = 1'b1;
        bus.speed = 2'b10;
        drive(8'h5A, 1'b1, 1'b0);
        step;
        chk_all("g_rst", 0, 4'h0, 4'h0, 0, 0, 0, 0);
        chk_status("g_rst", 2'b10, 0);
        rst = 1'b0;
        step;
        chk_all("g_rel", 1, 4'h0, 4'h0, 0, 0, 1, 0);
        step;
        chk_all("g_5a", 1, 4'hA, 4'h5, 1, 1, 1, 0);
        drive(8'hC3, 1'b1, 1'b0);
        step;
        chk_all("g_c3", 1, 4'h3, 4'hC, 1, 1, 1, 0);
        drive(8'hC3, 1'b1, 1'b1);
        step;
        chk_all("g_er", 1, 4'h3, 4'hC, 1, 0, 1, 0);
        drive(8'hC3, 1'b0, 1'b1);
        step;
        chk_all("g_noen", 1, 4'h3, 4'hC, 0, 1, 1, 0);
        chk_status("g_noen", 2'b10, 0);

        // 100 Mb/s from reset, byte 0x5A; speed to 1000 at cyc 2 of a LOW nibble
        rst = 1'b1;
        bus.speed = 2'b01;
        drive(8'h5A, 1'b1, 1'b0);
        step;
        chk_all("f_rst", 0, 4'h0, 4'h0, 0, 0, 0, 0);
        chk_status("f_rst", 2'b01, 0);
        rst = 1'b0;
        for (int k = 1; k <= 39; k++) begin
            step;
            tp     = pat5[k % 5];
            mce    = (k % 10 == 9);
            en_nib = (k < 10) ? 4'h0 : ((k % 10 < 5) ? 4'hA : 4'h5);
            c1     = (k >= 10);
            chk_all($sformatf("f100 k=%0d", k), mce, en_nib, en_nib, c1, c1, tp[1], tp[0]);
            chk_status($sformatf("f100 k=%0d", k), 2'b01, 0);
            if (k == 32) bus.speed = 2'b10;
            if (k == 35) drive(8'hC3, 1'b1, 1'b0);
        end
        step;
        chk_all("f2g k=40", 1, 4'h3, 4'hC, 1, 1, 1, 0);
        chk_status("f2g k=40", 2'b10, 1);
        step;
        chk_all("f2g k=41", 1, 4'h3, 4'hC, 1, 1, 1, 0);
        chk_status("f2g k=41", 2'b10, 0);

        // 1000 -> 100 restarts idle; then reset in the middle of a HIGH nibble
        bus.speed = 2'b01;
        for (int j = 0; j <= 16; j++) begin
            step;
            tp     = pat5[j % 5];
            mce    = (j % 10 == 9);
            en_nib = (j < 10) ? 4'h0 : ((j % 10 < 5) ? 4'h3 : 4'hC);
            c1     = (j >= 10);
            chk_all($sformatf("g2f j=%0d", j), mce, en_nib, en_nib, c1, c1, tp[1], tp[0]);
            chk_status($sformatf("g2f j=%0d", j), 2'b01, j == 0);
        end
        rst = 1'b1;
        step;
        chk_all("mid_rst", 0, 4'h0, 4'h0, 0, 0, 0, 0);
        chk_status("mid_rst", 2'b01, 0);
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step;
            chk($sformatf("post_rst k=%0d .mce", k), 32'(bus.mac_clk_en), 32'(k == 9));
            chk($sformatf("post_rst k=%0d .txd1", k), 32'(bus.txd_d1), (k < 10) ? 32'h0 : 32'h3);
        end

        // 10 Mb/s from reset, byte 0x3C with en=0 er=1
        rst = 1'b1;
        bus.speed = 2'b00;
        drive(8'h3C, 1'b0, 1'b1);
        step;
        chk_all("t_rst", 0, 4'h0, 4'h0, 0, 0, 0, 0);
        chk_status("t_rst", 2'b00, 0);
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step;
            c1     = (k % 50 < 25);
            mce    = (k % 100 == 99);
            en_nib = (k < 100) ? 4'h0 : ((k % 100 < 50) ? 4'hC : 4'h3);
            c2     = (k >= 100);
            chk_all($sformatf("t10 k=%0d", k), mce, en_nib, en_nib, 0, c2, c1, c1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
